// File: rtl/filter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// filter_seq_ctrl
//
// Sweeps the A/B select lines of the four-latch X/A/B input filter through
// all four code combinations in Gray order (00, 01, 11, 10). Each combination
// is held for PHASE_LEN cycles. The active-low X input is watched in every
// phase. At the end of one full sweep the block pulses done. pass is high
// only if X went low at least once in every phase.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a sweep (only honoured in IDLE)
//   abort  in   cancel a running sweep; beats start in IDLE
//   x      in   filter input under test, active-low event
//   a_out  out  A select to the filter (registered)
//   b_out  out  B select to the filter (registered)
//   busy   out  high while a sweep is running
//   done   out  one-cycle pulse at sweep completion
//   pass   out  sweep result, held until the next accepted start
//   hits   out  per-phase sticky X-low flags, bit n = phase n
// ---------------------------------------------------------------------------
module filter_seq_ctrl #(
    parameter int PHASE_LEN = 8     // cycles per phase, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       x,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] hits
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(PHASE_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [3:0] hits_q,  hits_d;
    logic       pass_q,  pass_d;
    logic       a_q,     a_d;
    logic       b_q,     b_d;

    // X-low seen on this edge, steered to the bit of the current phase.
    logic [3:0] hits_set;
    // Sticky flags including this edge's sample; used for the final pass
    // decision so the last sample of phase 3 is not lost.
    logic [3:0] hits_acc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hit
            assign hits_set[gi] = (phase_q == 2'(gi)) && !x;
        end
    endgenerate

    assign hits_acc = hits_q | hits_set;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        hits_d  = hits_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    phase_d = 2'd0;
                    cnt_d   = 8'd0;
                    hits_d  = 4'b0000;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                hits_d = hits_acc;
                if (abort) begin
                    // Partial hits are kept for diagnosis; pass is forced low.
                    state_d = S_IDLE;
                    phase_d = 2'd0;
                    cnt_d   = 8'd0;
                    pass_d  = 1'b0;
                end else if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (phase_q != 2'd3) begin
                    phase_d = phase_q + 2'd1;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_DONE;
                    phase_d = 2'd0;
                    cnt_d   = 8'd0;
                    pass_d  = &hits_acc;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Select lines follow the next phase so they switch on the same
        // edge the phase changes; forced to 00 outside RUN.
        // Gray decode: a = phase[1], b = phase[1] ^ phase[0].
        a_d = (state_d == S_RUN) && phase_d[1];
        b_d = (state_d == S_RUN) && (phase_d[1] ^ phase_d[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
            cnt_q   <= 8'd0;
            hits_q  <= 4'b0000;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign pass  = pass_q;
    assign hits  = hits_q;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_filter_seq_ctrl
//
// Self-checking bench for filter_seq_ctrl with PHASE_LEN=4. A reference
// model tracks each sweep as "edges elapsed since start" and derives the
// phase, select code and result from that count with plain arithmetic.
// Every clock is compared against the model; a hand-written vector table
// and directed sequences add fixed expectations for the corner cases.
// Output vector layout: {busy, done, a_out, b_out, pass, hits[3:0]}.
// ---------------------------------------------------------------------------
module tb_filter_seq_ctrl;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       x = 1'b1;
    logic       a_out, b_out, busy, done, pass;
    logic [3:0] hits;

    filter_seq_ctrl #(.PHASE_LEN(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .x     (x),
        .a_out (a_out),
        .b_out (b_out),
        .busy  (busy),
        .done  (done),
        .pass  (pass),
        .hits  (hits)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 running, 2 done cycle. m_e: edges since start.
    int         m_mode;
    int         m_e;
    logic [3:0] m_hits;
    logic       m_pass;
    bit         ga[4];
    bit         gb[4];

    task automatic model_reset();
        m_mode = 0;
        m_e    = 0;
        m_hits = 4'b0000;
        m_pass = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic ab, input logic xx);
        int j;
        case (m_mode)
            1: begin
                j = m_e + 1;
                // Sample on edge k+j belongs to phase (j-1)/L.
                if (!xx) m_hits[2'((j - 1) / L)] = 1'b1;
                if (ab) begin
                    m_mode = 0;
                    m_pass = 1'b0;
                end else if (j == 4 * L) begin
                    m_mode = 2;
                    m_pass = &m_hits;
                end else begin
                    m_e = j;
                end
            end
            2: m_mode = 0;
            default: begin
                if (st && !ab) begin
                    m_mode = 1;
                    m_e    = 0;
                    m_hits = 4'b0000;
                    m_pass = 1'b0;
                end
            end
        endcase
    endtask

    function automatic logic [8:0] model_vec();
        int   ph;
        logic ea, eb;
        ph = (m_mode == 1) ? (m_e / L) : 0;
        ea = (m_mode == 1) ? ga[ph] : 1'b0;
        eb = (m_mode == 1) ? gb[ph] : 1'b0;
        return {(m_mode == 1), (m_mode == 2), ea, eb, m_pass, m_hits};
    endfunction

    function automatic logic [8:0] act_vec();
        return {busy, done, a_out, b_out, pass, hits};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model,
    // compare 1 ns later, finish on the falling edge.
    task automatic tick(input logic st, input logic ab, input logic xx, output logic [8:0] v);
        start = st;
        abort = ab;
        x     = xx;
        @(posedge clk);
        model_step(st, ab, xx);
        #1;
        v = act_vec();
        check("model", v, model_vec());
        @(negedge clk);
    endtask

    // Full sweep started at local edge 0, run through edge 17; x low on the
    // edges flagged in lowmask.
    task automatic sweep(input string name, input logic [63:0] lowmask,
                         input logic exp_pass, input logic [3:0] exp_hits);
        logic [8:0] v;
        int         done_at;
        done_at = -1;
        for (int n = 0; n < 18; n++) begin
            tick(n == 0, 1'b0, !lowmask[n], v);
            if (v[7]) done_at = n;
        end
        check({name, "_done_edge"}, done_at, 16);
        check({name, "_pass"}, pass, exp_pass);
        check({name, "_hits"}, hits, exp_hits);
        $display("sweep %s: done_edge=%0d pass=%0b hits=%b", name, done_at, pass, hits);
    endtask

    typedef struct {
        logic       st;
        logic       ab;
        logic       xx;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] v;
        logic [63:0] mask;
        int starts[$];
        logic prev_busy;
        int done_at;

        ga[0] = 0; ga[1] = 0; ga[2] = 1; ga[3] = 1;
        gb[0] = 0; gb[1] = 1; gb[2] = 1; gb[3] = 0;
        model_reset();

        // Vectors for a PHASE_LEN=4 sweep, x low on edges 2, 6, 10, 14;
        // edge 17 x low in the done-follow-up cycle is ignored; edge 18
        // start+abort together in IDLE does nothing.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 9'b1_0_00_0_0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_00_0_0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 9'b1_0_00_0_0001};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_00_0_0001};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_01_0_0001};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 9'b1_0_01_0_0001};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 9'b1_0_01_0_0011};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_01_0_0011};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_11_0_0011};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 9'b1_0_11_0_0011};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 9'b1_0_11_0_0111};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 9'b1_0_11_0_0111};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 9'b1_0_10_0_0111};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 9'b1_0_10_0_0111};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 9'b1_0_10_0_1111};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 9'b1_0_10_0_1111};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 9'b0_1_00_1_1111};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 9'b0_0_00_1_1111};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 9'b0_0_00_1_1111};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", act_vec(), 9'd0);
        $display("reset: outputs=%b", act_vec());
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven basic sweep
        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].st, tbl[i].ab, tbl[i].xx, v);
            check($sformatf("table_row%0d", i), v, tbl[i].exp);
            $display("table edge %0d: start=%0b abort=%0b x=%0b out=%b", i,
                     tbl[i].st, tbl[i].ab, tbl[i].xx, v);
        end

        // Phase 2 never sees x low
        mask = (64'd1 << 2) | (64'd1 << 6) | (64'd1 << 14);
        sweep("miss_phase2", mask, 1'b0, 4'b1011);
        // Last edge of each phase still counts for that phase
        mask = (64'd1 << 4) | (64'd1 << 8) | (64'd1 << 12) | (64'd1 << 16);
        sweep("last_edges", mask, 1'b1, 4'b1111);
        // Low only in the done cycle: ignored
        mask = 64'd1 << 17;
        sweep("after_done", mask, 1'b0, 4'b0000);

        // Abort at edge 7, then restart at edge 8
        done_at = -1;
        for (int n = 0; n < 8; n++) begin
            tick(n == 0, n == 7, !(n == 2 || n == 5), v);
            if (v[7]) done_at = n;
        end
        check("abort_busy", busy, 1'b0);
        check("abort_pass", pass, 1'b0);
        check("abort_hits", hits, 4'b0011);
        check("abort_ab", {a_out, b_out}, 2'b00);
        $display("abort: busy=%0b pass=%0b hits=%b", busy, pass, hits);
        for (int n = 8; n < 27; n++) begin
            tick(n == 8, 1'b0, 1'b0, v);
            if (v[7]) done_at = n;
        end
        check("restart_done_edge", done_at, 24);
        check("restart_pass", pass, 1'b1);
        check("restart_hits", hits, 4'b1111);
        $display("restart: done_edge=%0d pass=%0b hits=%b", done_at, pass, hits);

        // start held high: sweeps begin at edges 0, 18, 36
        prev_busy = 1'b0;
        for (int n = 0; n < 41; n++) begin
            tick(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0), v);
            if (v[8] && !prev_busy) starts.push_back(n);
            prev_busy = v[8];
        end
        check("held_count", starts.size(), 3);
        if (starts.size() == 3) begin
            check("held_start1", starts[0], 0);
            check("held_start2", starts[1], 18);
            check("held_start3", starts[2], 36);
        end
        $display("start_held: %0d sweeps started", starts.size());
        tick(1'b0, 1'b1, 1'b1, v);

        // Asynchronous reset in the middle of phase 1
        for (int n = 0; n < 6; n++) tick(n == 0, 1'b0, 1'b0, v);
        check("pre_reset_ab", {a_out, b_out}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", act_vec(), 9'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold", act_vec(), 9'd0);
        $display("async reset: outputs=%b", act_vec());
        @(negedge clk);
        rst_n = 1'b1;
        sweep("post_reset", '1, 1'b1, 4'b1111);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 47) == 0),
                 1'($urandom_range(0, 4) != 0), v);
            if (v[7]) $display("random sweep done at cycle %0d: pass=%0b hits=%b", n, v[4], v[3:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
